// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned TAG_W = 4;

  typedef enum logic [1:0] {StIdle, StOwn, StAbort, StDrain} arb_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module wb_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] hi_idx, lo_idx;
  logic            hi_vld, lo_vld;

  // Descending scans leave the lowest qualifying index in place.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = IdxW'(i);
        lo_vld = 1'b1;
        if (i >= int'(ptr_i)) begin
          hi_idx = IdxW'(i);
          hi_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    idx_o   = hi_vld ? hi_idx : lo_idx;
    valid_o = lo_vld;
    gnt_o   = '0;
    if (lo_vld) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters, held per CYC.
// Optional slave-timeout watchdog: define WB_RR_ARBITER_WATCHDOG_EN.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [ADR_W*NUM_MASTERS-1:0] m_adr_i,
  input  logic [DAT_W*NUM_MASTERS-1:0] m_dat_i,
  input  logic [SEL_W*NUM_MASTERS-1:0] m_sel_i,
  input  logic [TAG_W*NUM_MASTERS-1:0] m_tag_i,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [NUM_MASTERS-1:0]       m_rty_o,
  output logic [DAT_W-1:0]             m_dat_o,
  output logic [TAG_W-1:0]             m_tag_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [ADR_W-1:0]             s_adr_o,
  output logic [DAT_W-1:0]             s_dat_o,
  output logic [SEL_W-1:0]             s_sel_o,
  output logic [TAG_W-1:0]             s_tag_o,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  input  logic                         s_rty_i,
  input  logic [DAT_W-1:0]             s_dat_i,
  input  logic [TAG_W-1:0]             s_tag_i,
  output logic [NUM_MASTERS-1:0]       gnt_o
);

  localparam int unsigned IdxW = clog2(NUM_MASTERS);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IdxW-1:0]        own_q, ptr_q;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_vld;

  wb_rr_pick #(
    .N    (NUM_MASTERS),
    .IdxW (IdxW)
  ) u_pick (
    .req_i   (m_cyc_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

`ifdef WB_RR_ARBITER_WATCHDOG_EN
  localparam int unsigned CntW = clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;
  logic            term;
  assign term = s_ack_i | s_err_i | s_rty_i;
`endif

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
`ifdef WB_RR_ARBITER_WATCHDOG_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            state_q <= StOwn;
            gnt_q   <= pick_gnt;
            own_q   <= pick_idx;
            ptr_q   <= (pick_idx == IdxW'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
        StOwn: begin
          if (!m_cyc_i[own_q]) begin
            state_q <= StIdle;
            gnt_q   <= '0;
          end
`ifdef WB_RR_ARBITER_WATCHDOG_EN
          else if (cnt_q == CntW'(TIMEOUT)) begin
            state_q <= StAbort;
          end
`endif
        end
`ifdef WB_RR_ARBITER_WATCHDOG_EN
        StAbort: state_q <= StDrain;
        StDrain: begin
          if (!m_cyc_i[own_q]) begin
            state_q <= StIdle;
            gnt_q   <= '0;
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
        end
      endcase
`ifdef WB_RR_ARBITER_WATCHDOG_EN
      // Counts only stalled strobes of the current owner; saturates into ABORT.
      if (state_q == StOwn && m_cyc_i[own_q] && s_stb_o && !term && cnt_q != CntW'(TIMEOUT)) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
`endif
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_tag_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (state_q == StOwn) begin
      s_cyc_o        = m_cyc_i[own_q];
      s_stb_o        = m_stb_i[own_q];
      s_we_o         = m_we_i[own_q];
      s_adr_o        = m_adr_i[own_q*ADR_W +: ADR_W];
      s_dat_o        = m_dat_i[own_q*DAT_W +: DAT_W];
      s_sel_o        = m_sel_i[own_q*SEL_W +: SEL_W];
      s_tag_o        = m_tag_i[own_q*TAG_W +: TAG_W];
      m_ack_o[own_q] = s_ack_i;
      m_err_o[own_q] = s_err_i;
      m_rty_o[own_q] = s_rty_i;
    end
`ifdef WB_RR_ARBITER_WATCHDOG_EN
    if (state_q == StAbort) m_err_o[own_q] = 1'b1;
`endif
  end

  assign m_dat_o = s_dat_i;
  assign m_tag_o = s_tag_i;
  assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter with four masters.
module tb_wb_rr_arbiter;
  localparam int N = 4;

  logic            CLK_I = 1'b0;
  logic            RST_I;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [32*N-1:0] m_adr_i, m_dat_i;
  logic [4*N-1:0]  m_sel_i, m_tag_i;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o, gnt_o;
  logic [31:0]     m_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]      m_tag_o, s_sel_o, s_tag_o, s_tag_i;
  logic            s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(8)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_tag_i(m_tag_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .m_dat_o(m_dat_o), .m_tag_o(m_tag_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_tag_o(s_tag_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .s_dat_i(s_dat_i), .s_tag_i(s_tag_i), .gnt_o(gnt_o)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic tick;
    @(posedge CLK_I);
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc_i[i]          = cyc;
    m_stb_i[i]          = stb;
    m_we_i[i]           = we;
    m_adr_i[32*i +: 32] = adr;
    m_dat_i[32*i +: 32] = dat;
    m_sel_i[4*i +: 4]   = sel;
    m_tag_i[4*i +: 4]   = 4'(i + 1);
  endtask

  task automatic clear_inputs;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_tag_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    s_dat_i = '0; s_tag_i = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    RST_I = 1'b1;
    tick();
    RST_I = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    clear_inputs();
    RST_I   = 1'b1;
    s_dat_i = 32'h1234_5678;
    s_tag_i = 4'hA;
    #2;
    n_cmp++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
    n_cmp++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got %b want 0", s_cyc_o); end
    n_cmp++; if (m_ack_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", m_ack_o); end
    n_cmp++; if (m_dat_o !== 32'h1234_5678) begin n_fail++; $display("FAIL dat_bcast: got %h want 12345678", m_dat_o); end
    n_cmp++; if (m_tag_o !== 4'hA) begin n_fail++; $display("FAIL tag_bcast: got %h want a", m_tag_o); end
    tick();
    RST_I = 1'b0;
    #1;
  endtask

  task automatic test_single_write;
    set_m(2, 1'b1, 1'b1, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    #1;
    n_cmp++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL wr_latency: s_cyc got %b want 0", s_cyc_o); end
    n_cmp++; if (s_adr_o !== 32'h0) begin n_fail++; $display("FAIL idle_adr: got %h want 0", s_adr_o); end
    tick();
    n_cmp++; if (gnt_o !== 4'b0100) begin n_fail++; $display("FAIL wr_gnt: got %b want 0100", gnt_o); end
    n_cmp++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b111) begin n_fail++; $display("FAIL wr_ctl: got %b want 111", {s_cyc_o, s_stb_o, s_we_o}); end
    n_cmp++; if (s_adr_o !== 32'h4000_0010) begin n_fail++; $display("FAIL wr_adr: got %h want 40000010", s_adr_o); end
    n_cmp++; if (s_dat_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_dat: got %h want deadbeef", s_dat_o); end
    n_cmp++; if (s_sel_o !== 4'hF) begin n_fail++; $display("FAIL wr_sel: got %h want f", s_sel_o); end
    n_cmp++; if (s_tag_o !== 4'h3) begin n_fail++; $display("FAIL wr_tag: got %h want 3", s_tag_o); end
    // Owner drops CYC in the same cycle the slave acks.
    s_ack_i = 1'b1;
    set_m(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    n_cmp++; if (m_ack_o !== 4'b0100) begin n_fail++; $display("FAIL wr_ack: got %b want 0100", m_ack_o); end
    tick();
    s_ack_i = 1'b0;
    #1;
    n_cmp++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL wr_release: got %b want 0000", gnt_o); end
    n_cmp++; if (m_ack_o !== 4'b0000) begin n_fail++; $display("FAIL wr_ack_idle: got %b want 0000", m_ack_o); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < N; i++) set_m(i, 1'b1, 1'b1, 1'b0, 32'(i * 16), 32'h0, 4'hF);
    tick();
    for (int i = 0; i < N; i++) begin
      exp = 4'b0001 << i;
      n_cmp++; if (gnt_o !== exp) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", i, gnt_o, exp); end
      n_cmp++; if (s_adr_o !== 32'(i * 16)) begin n_fail++; $display("FAIL rr_adr%0d: got %h want %h", i, s_adr_o, 32'(i * 16)); end
      s_ack_i = 1'b1;
      s_dat_i = 32'hC0DE_0000 + 32'(i);
      set_m(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      n_cmp++; if (m_ack_o !== exp) begin n_fail++; $display("FAIL rr_ack%0d: got %b want %b", i, m_ack_o, exp); end
      n_cmp++; if (m_dat_o !== 32'hC0DE_0000 + 32'(i)) begin n_fail++; $display("FAIL rr_rdat%0d: got %h", i, m_dat_o); end
      tick();
      s_ack_i = 1'b0;
      #1;
      n_cmp++; if ({gnt_o, s_cyc_o} !== 5'b0) begin n_fail++; $display("FAIL rr_gap%0d: got %b want 00000", i, {gnt_o, s_cyc_o}); end
      tick();
    end
  endtask

  task automatic test_rmw;
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    set_m(3, 1'b1, 1'b1, 1'b1, 32'h300, 32'h33, 4'hF);
    tick();
    n_cmp++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL rmw_gnt: got %b want 0010", gnt_o); end
    s_ack_i = 1'b1;
    #1;
    n_cmp++; if (m_ack_o !== 4'b0010) begin n_fail++; $display("FAIL rmw_rd_ack: got %b want 0010", m_ack_o); end
    tick();
    s_ack_i = 1'b0;
    m_stb_i[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if ({gnt_o, s_cyc_o, s_stb_o} !== 6'b0010_10) begin n_fail++; $display("FAIL rmw_gap%0d: got %b want 001010", k, {gnt_o, s_cyc_o, s_stb_o}); end
    end
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h55, 4'hF);
    tick();
    n_cmp++; if ({gnt_o, s_cyc_o, s_we_o} !== 6'b0010_11) begin n_fail++; $display("FAIL rmw_wr: got %b want 001011", {gnt_o, s_cyc_o, s_we_o}); end
    s_ack_i = 1'b1;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    n_cmp++; if (m_ack_o !== 4'b0010) begin n_fail++; $display("FAIL rmw_wr_ack: got %b want 0010", m_ack_o); end
    tick();
    s_ack_i = 1'b0;
    #1;
    n_cmp++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL rmw_idle: got %b want 0000", gnt_o); end
    tick();
    n_cmp++; if (gnt_o !== 4'b1000) begin n_fail++; $display("FAIL rmw_next: got %b want 1000", gnt_o); end
    set_m(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
  endtask

  task automatic test_retry;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    tick();
    n_cmp++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL rty_gnt: got %b want 0001", gnt_o); end
    s_rty_i = 1'b1;
    #1;
    n_cmp++; if (m_rty_o !== 4'b0001) begin n_fail++; $display("FAIL rty_route: got %b want 0001", m_rty_o); end
    n_cmp++; if ({m_ack_o, m_err_o} !== 8'b0) begin n_fail++; $display("FAIL rty_other: got %b want 0", {m_ack_o, m_err_o}); end
    tick();
    s_rty_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    n_cmp++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL rty_release: got %b want 0000", gnt_o); end
    tick();
    n_cmp++; if (gnt_o !== 4'b0100) begin n_fail++; $display("FAIL rty_next: got %b want 0100", gnt_o); end
  endtask

  task automatic test_mid_reset;
    // Master 2 still owns from the retry test.
    n_cmp++; if ({s_cyc_o, s_stb_o} !== 2'b11) begin n_fail++; $display("FAIL mr_pre: got %b want 11", {s_cyc_o, s_stb_o}); end
    #2;
    RST_I = 1'b1;
    #1;
    n_cmp++; if ({gnt_o, s_cyc_o, s_stb_o} !== 6'b0) begin n_fail++; $display("FAIL mr_async: got %b want 000000", {gnt_o, s_cyc_o, s_stb_o}); end
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    tick();
    RST_I = 1'b0;
    tick();
    n_cmp++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL mr_prio: got %b want 0001", gnt_o); end
  endtask

`ifdef WB_RR_ARBITER_WATCHDOG_EN
  task automatic test_watchdog;
    do_reset();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h90, 32'h0, 4'hF);
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if ({m_err_o, s_cyc_o} !== 5'b0000_1) begin n_fail++; $display("FAIL wd_wait%0d: got %b want 00001", k, {m_err_o, s_cyc_o}); end
    end
    tick();
    n_cmp++; if (m_err_o !== 4'b0001) begin n_fail++; $display("FAIL wd_err: got %b want 0001", m_err_o); end
    n_cmp++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin n_fail++; $display("FAIL wd_cut: got %b want 00", {s_cyc_o, s_stb_o}); end
    tick();
    n_cmp++; if ({m_err_o, s_cyc_o} !== 5'b0) begin n_fail++; $display("FAIL wd_pulse: got %b want 00000", {m_err_o, s_cyc_o}); end
    n_cmp++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL wd_drain: got %b want 0001", gnt_o); end
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    n_cmp++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL wd_idle: got %b want 0000", gnt_o); end
    tick();
    n_cmp++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL wd_regrant: got %b want 0010", gnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_rmw();
    test_retry();
    test_mid_reset();
`ifdef WB_RR_ARBITER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin arbiter sharing one 32-bit Wishbone slave port among NUM_MASTERS behavioural or RTL Wishbone masters on the bench/system bus. It grants the bus per CYC ownership, so block and RMW cycles are never interleaved. It routes ACK/ERR/RTY and read data back to the owner only. An optional watchdog aborts cycles that the slave never terminates.

## Interface
- NUM_MASTERS, 4: number of requesting masters, 2..8
- TIMEOUT, 255: watchdog limit in cycles; used only when the watchdog is compiled in
- CLK_I  in  1  clock; all state updates on rising edge
- RST_I  in  1  reset, asynchronous, active-high
- m_cyc_i / m_stb_i / m_we_i  in  NUM_MASTERS each  per-master Wishbone request signals
- m_adr_i  in  32*NUM_MASTERS  addresses; master i occupies bits [32i+31:32i]
- m_dat_i  in  32*NUM_MASTERS  write data, same packing as m_adr_i
- m_sel_i / m_tag_i  in  4*NUM_MASTERS each  byte selects and tags
- m_ack_o / m_err_o / m_rty_o  out  NUM_MASTERS each  terminations, owner bit only
- m_dat_o  out  32  read data, broadcast to all masters
- m_tag_o  out  4  slave tag, broadcast to all masters
- s_cyc_o / s_stb_o / s_we_o  out  1 each  slave-side request
- s_adr_o / s_dat_o  out  32 each  slave-side address and write data
- s_sel_o / s_tag_o  out  4 each  slave-side byte selects and tag
- s_ack_i / s_err_i / s_rty_i  in  1 each  slave terminations
- s_dat_i  in  32  slave read data
- s_tag_i  in  4  slave tag
- gnt_o  out  NUM_MASTERS  one-hot current owner; zero when the bus is free

## Operation
- States: IDLE, OWN. When the watchdog is compiled in, also ABORT and DRAIN.
- IDLE: the request vector is m_cyc_i. The picker searches from pointer ptr upward, modulo NUM_MASTERS, and takes the first set bit. At that edge: gnt_o becomes the winner (one-hot), ptr becomes winner+1 mod N, and the state moves to OWN. With no request, the state stays IDLE.
- OWN, outputs (combinational mux of the owner):
  - s_cyc_o = m_cyc_i[own]; s_stb_o = m_stb_i[own]; s_we_o, s_adr_o, s_dat_o, s_sel_o and s_tag_o all come from the owner.
  - m_ack_o[own] = s_ack_i. ERR and RTY are routed to the owner the same way.
  - Every non-owner termination bit is 0.
- OWN, hold and release:
  - The grant is held for as long as m_cyc_i[own] stays high. STB gaps inside a block or RMW cycle do not release it.
  - The edge that samples m_cyc_i[own]=0 moves the state to IDLE and clears gnt_o.
- m_dat_o = s_dat_i and m_tag_o = s_tag_i at all times.
- Outside OWN: s_cyc_o, s_stb_o and s_we_o are 0, all slave-side vectors are 0, and all m_*_o termination bits are 0.
- Slave ERR/RTY are passed to the owner. The owner is expected to drop CYC; the arbiter does not force release except through the watchdog.
- Reset, including mid-cycle: state=IDLE, gnt_o=0, ptr=0, watchdog count=0. All outputs go to 0 immediately (asynchronously).

## Timing
- Grant latency: the owner's CYC/STB appear on the slave port in the cycle after the first edge that samples m_cyc_i high in IDLE (1 cycle).
- Termination path: combinational, zero latency from slave to owner.
- Hand-over between owners: at least 1 IDLE cycle. Edge A samples the owner's CYC low; edge A+1 grants the next master.
- Simultaneous requests in IDLE are resolved strictly by ptr; after reset, master 0 wins.
- If the owner drops CYC in the same cycle the slave ACKs, the ACK is still delivered; the release happens at that edge.

## Configuration
- Macro: WB_RR_ARBITER_WATCHDOG_EN.
- Defined:
  - Counter width is clog2(TIMEOUT+1). In OWN it increments each cycle that s_stb_o=1 and s_ack_i|s_err_i|s_rty_i=0. It clears on any termination, when STB is low, or on leaving OWN.
  - When the count equals TIMEOUT, the state moves to ABORT.
  - ABORT (exactly 1 cycle): m_err_o[own]=1, s_cyc_o=s_stb_o=0.
  - DRAIN: slave disconnected until m_cyc_i[own]=0, then IDLE.
- Undefined: no counter, no ABORT/DRAIN states; a silent slave holds the bus indefinitely.

## Structure
- Package wb_arb_pkg: state enum, ADR_W=32, DAT_W=32, SEL_W=4, TAG_W=4, and a clog2 function.
- Sub-module wb_rr_pick: combinational picker. Inputs: request vector and ptr. Outputs: one-hot grant, index, and valid.

## Test plan
- Single master 2 writes 32'hDEAD_BEEF to 32'h4000_0010 with sel 4'hF. Required: gnt_o=4'b0100; slave sees the same ADR, DAT and SEL one cycle after CYC; m_ack_o=4'b0100; other ACK bits stay 0.
- All four masters raise CYC simultaneously after reset, each doing a single read. Required: grant order 0,1,2,3, with exactly one IDLE cycle between consecutive grants.
- Master 1 does an RMW (read then write, CYC held, STB gap) while master 3 requests. Required: master 3 is not granted until master 1 drops CYC; slave CYC never drops in between.
- Slave asserts RTY to owner 0. Required: m_rty_o=4'b0001 in the same cycle; after master 0 drops CYC, the next requester is granted.
- Watchdog on, TIMEOUT=8, slave never ACKs. Required:
  - m_err_o[own] pulses for exactly 1 cycle, 9 cycles after STB rises;
  - s_cyc_o falls with the pulse;
  - the bus is re-granted after the owner drops CYC.
- RST_I pulsed mid-burst. Required: s_cyc_o, s_stb_o and gnt_o go to 0 asynchronously; after reset, master 0 has priority.
